kernel_load_ctrl: RTL and testbench

KERNEL_LOAD_CTRL -- requirements
Module: kernel_load_ctrl

---
 rtl/kernel_load_ctrl.sv | 89 ++++++++
 tb/tb_kernel_load_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/kernel_load_ctrl.sv
// kernel_load_ctrl: sequences 4-row weight loads for NEURONS kernels from a
// weight memory, one outstanding read at a time.
//
// Ports:
//   i_clock       sole clock, rising edge
//   i_reset_n     asynchronous active-low reset
//   i_start       load request, sampled only while idle
//   i_base_addr   address of neuron 0 row 0, captured on accepted start
//   o_mem_rd      one-cycle read strobe
//   o_mem_addr    read address, base + 4*n + r (wraps modulo 2^ADDR_W)
//   i_mem_valid   read data valid this cycle (data goes straight to the bank)
//   o_load        one-hot row-write enable, bit n selects kernel n
//   o_index       kernel row being written
//   o_busy        high whenever not idle
//   o_done        one-cycle pulse after the last row is written
module kernel_load_ctrl #(
    parameter int NEURONS = 2,
    parameter int ADDR_W  = 8
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic [ADDR_W-1:0]  i_base_addr,
    output logic               o_mem_rd,
    output logic [ADDR_W-1:0]  o_mem_addr,
    input  logic               i_mem_valid,
    output logic [NEURONS-1:0] o_load,
    output logic [1:0]         o_index,
    output logic               o_busy,
    output logic               o_done
);
    localparam int NW = NEURONS > 1 ? $clog2(NEURONS) : 1;
    localparam logic [NW-1:0] N_LAST = NW'(NEURONS - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [NW-1:0]     r_n;
    logic [1:0]        r_r;
    logic [ADDR_W-1:0] r_base;
    logic              w_accept;
    logic              w_ack;
    logic              w_last;

    assign w_accept = (r_state == IDLE) && i_start;
    assign w_ack    = (r_state == WAIT) && i_mem_valid;
    assign w_last   = (r_r == 2'd3) && (r_n == N_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_start ? REQ : IDLE;
            REQ:     w_next = WAIT;
            WAIT:    w_next = i_mem_valid ? (w_last ? DONE : REQ) : WAIT;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
            r_n     <= '0;
            r_r     <= '0;
            r_base  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_base <= i_base_addr;
                r_n    <= '0;
                r_r    <= '0;
            end else if (w_ack) begin
                // r wraps 3->0 naturally; n only steps when a neuron's rows are done
                r_r <= r_r + 2'd1;
                if (r_r == 2'd3 && r_n != N_LAST)
                    r_n <= r_n + NW'(1);
            end
        end
    end

    // {n, r} is exactly 4*n + r
    assign o_mem_addr = r_base + ADDR_W'({r_n, r_r});
    assign o_mem_rd   = (r_state == REQ);
    assign o_load     = w_ack ? (NEURONS'(1) << r_n) : '0;
    assign o_index    = r_r;
    assign o_busy     = (r_state != IDLE);
    assign o_done     = (r_state == DONE);
endmodule

// File: tb/tb_kernel_load_ctrl.sv
// tb_kernel_load_ctrl: scoreboard bench for kernel_load_ctrl (NEURONS=2, ADDR_W=8)
// with a variable-latency memory model, stray mem_valid / start injection and
// a mid-sequence asynchronous reset.
module tb_kernel_load_ctrl;
    localparam int N = 2;

    logic       clk = 1'b0;
    logic       i_reset_n;
    logic       i_start;
    logic [7:0] i_base_addr;
    logic       o_mem_rd;
    logic [7:0] o_mem_addr;
    logic       i_mem_valid;
    logic [N-1:0] o_load;
    logic [1:0] o_index;
    logic       o_busy;
    logic       o_done;

    int checks = 0;
    int failures = 0;
    int busy_cnt = 0;
    int lat = 1;
    int mcnt = 0;
    logic noisy = 1'b0;
    logic stray_idle = 1'b0;
    logic resp;

    logic [7:0] q_addr[$];
    logic [3:0] q_load[$];

    always #5 clk = ~clk;

    kernel_load_ctrl #(.NEURONS(N), .ADDR_W(8)) dut (
        .i_clock    (clk),
        .i_reset_n  (i_reset_n),
        .i_start    (i_start),
        .i_base_addr(i_base_addr),
        .o_mem_rd   (o_mem_rd),
        .o_mem_addr (o_mem_addr),
        .i_mem_valid(i_mem_valid),
        .o_load     (o_load),
        .o_index    (o_index),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    // Memory answers lat cycles after the cycle carrying the read strobe
    always @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) mcnt <= 0;
        else if (o_mem_rd) mcnt <= lat;
        else if (mcnt != 0) mcnt <= mcnt - 1;
    end
    assign resp = (mcnt == 1);
    assign i_mem_valid = resp | stray_idle | (noisy & (o_mem_rd | o_done));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (i_reset_n) begin
            if (o_busy) busy_cnt++;
            if (o_mem_rd) begin
                check("rd_expected", 32'(q_addr.size() != 0), 32'd1);
                if (q_addr.size() != 0) check("mem_addr", 32'(o_mem_addr), 32'(q_addr.pop_front()));
            end
            if (o_load != '0) begin
                check("ld_expected", 32'(q_load.size() != 0), 32'd1);
                check("ld_valid", 32'(i_mem_valid), 32'd1);
                if (q_load.size() != 0) check("load_index", 32'({o_load, o_index}), 32'(q_load.pop_front()));
            end
        end
    end

    task automatic push_seq(input logic [7:0] base);
        for (int n = 0; n < N; n++)
            for (int r = 0; r < 4; r++) begin
                q_addr.push_back(base + 8'(4 * n + r));
                q_load.push_back({2'(1 << n), 2'(r)});
            end
    endtask

    task automatic run_seq(input logic [7:0] base, input int l, input logic nz, input int exp_done);
        int cyc;
        lat = l;
        push_seq(base);
        @(negedge clk);
        busy_cnt = 0;
        noisy = nz;
        i_base_addr = base;
        i_start = 1'b1;
        stray_idle = nz;
        @(negedge clk);
        i_start = 1'b0;
        stray_idle = 1'b0;
        i_base_addr = ~base;
        cyc = 1;
        while (!o_done && cyc < 200) begin
            i_start = nz && (cyc % 5 == 2);
            @(negedge clk);
            cyc++;
        end
        i_start = 1'b0;
        check("done_cycle", 32'(cyc), 32'(exp_done));
        @(negedge clk);
        check("idle_busy", 32'(o_busy), 32'd0);
        check("idle_done", 32'(o_done), 32'd0);
        check("busy_cycles", 32'(busy_cnt), 32'(exp_done));
        check("addr_q_empty", 32'(q_addr.size()), 32'd0);
        check("load_q_empty", 32'(q_load.size()), 32'd0);
        noisy = 1'b0;
    endtask

    initial begin
        int cyc;
        i_reset_n = 1'b0;
        i_start = 1'b0;
        i_base_addr = 8'h00;
        #12;
        check("rst_mem_rd", 32'(o_mem_rd), 32'd0);
        check("rst_load", 32'(o_load), 32'd0);
        check("rst_index", 32'(o_index), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        @(negedge clk);
        i_reset_n = 1'b1;

        run_seq(8'h10, 1, 1'b0, 17);
        run_seq(8'h10, 3, 1'b0, 33);
        run_seq(8'hFE, 1, 1'b0, 17);
        run_seq(8'h10, 1, 1'b1, 17);

        // start held high through DONE, then reset during neuron 1 row 2
        lat = 1;
        push_seq(8'h20);
        push_seq(8'h20);
        @(negedge clk);
        i_base_addr = 8'h20;
        i_start = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (!o_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("held_done_cycle", 32'(cyc), 32'd17);
        @(negedge clk);
        check("held_idle_busy", 32'(o_busy), 32'd0);
        check("held_idle_rd", 32'(o_mem_rd), 32'd0);
        @(negedge clk);
        check("held_restart_rd", 32'(o_mem_rd), 32'd1);
        check("held_restart_addr", 32'(o_mem_addr), 32'h20);
        i_start = 1'b0;
        cyc = 0;
        while (!(o_mem_rd && o_mem_addr == 8'h26) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_n1_r2", 32'(cyc < 100), 32'd1);
        #1 i_reset_n = 1'b0;
        #1;
        check("arst_mem_rd", 32'(o_mem_rd), 32'd0);
        check("arst_load", 32'(o_load), 32'd0);
        check("arst_index", 32'(o_index), 32'd0);
        check("arst_busy", 32'(o_busy), 32'd0);
        check("arst_done", 32'(o_done), 32'd0);
        q_addr.delete();
        q_load.delete();
        repeat (3) begin
            @(negedge clk);
            check("arst_no_done", 32'(o_done), 32'd0);
        end
        i_reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 32'(o_busy), 32'd0);

        run_seq(8'h40, 1, 1'b0, 17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
